ppu_fb_writer: RTL and testbench
================================

# ppu_fb_writer

Pixel sink directly downstream of the PPU pixel FIFO. Accepts the PPU's 2-bit colour indices, maps them through the BGP palette to shades, tags each with a linear frame-buffer address (y*160 + x), and writes them to the frame-buffer memory port through a small decoupling FIFO with a wait-request handshake. It also resynchronises its x/y position on PPU mode changes and reports frame completion and error conditions.

## Interface
Parameters:
- FIFO_DEPTH, 16, entries in the decoupling FIFO (power of two)
- LINE_W, 160, pixels per line
- LINES, 144, visible lines per frame
- ADDR_W, 15, frame-buffer address width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- PX_IN  in  2  colour index from the PPU shifter
- PX_valid  in  1  PX_IN valid this cycle
- PPU_MODE  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
- BGP  in  8  background palette register
- CLR_STATUS  in  1  one-cycle pulse that clears the sticky flags
- FB_ADDR  out  ADDR_W  frame-buffer write address
- FB_DATA  out  2  shade to write
- FB_WR  out  1  write request
- FB_WAIT  in  1  memory stall; the write is accepted when FB_WR && !FB_WAIT
- FRAME_DONE  out  1  one-cycle pulse when the last pixel of a frame is retired
- OVERFLOW  out  1  sticky flag: a pixel was dropped because the FIFO was full
- SHORT_LINE  out  1  sticky flag: H_BLANK was entered mid-line

## Operation
- Shade: shade = BGP[2*PX_IN+1 : 2*PX_IN], using the BGP value present in the accept cycle.
- Position counters: x (0..159), y (0..143), addr (0..23039), and line_base (y*160).
  - Advance on every cycle with PX_valid, including cycles where the pixel is dropped, so geometry stays correct.
  - Normal pixel: x+1, addr+1.
  - At x==159: x=0, y+1, line_base+=160, addr=line_base+160.
  - At x==159 and y==143: x=y=addr=line_base=0; the entry is tagged last-of-frame.
- H_BLANK resync: on the cycle PPU_MODE changes from any other mode to 0 while x!=0:
  - x=0, y+1 (wraps to 0 after 143), line_base+=160, addr=new line_base.
  - Set SHORT_LINE.
- V_BLANK resync: on the cycle PPU_MODE changes from any other mode to 1, set x=y=addr=line_base=0.
  - Entries already queued still drain.
- If PX_valid coincides with a mode edge, the pixel uses the pre-resync position and the resync overrides the counter update.
- FIFO: each entry is {last, addr, shade}.
  - Push on PX_valid unless full.
  - A push while full with no pop drops the pixel and sets OVERFLOW.
  - A push while full with a pop in the same cycle is accepted; count stays at FIFO_DEPTH.
- Output: FB_WR = FIFO not empty. FB_ADDR and FB_DATA show the head entry.
  - The head pops when FB_WR && !FB_WAIT.
  - If the popped entry has last=1, FRAME_DONE pulses in the following cycle.
- Sticky flags:
  - CLR_STATUS clears both flags.
  - A set and a clear in the same cycle: set wins.
- Suggested implementation: a register-based FIFO with a count; counters as described; mode-edge detection on the registered PPU_MODE.

## Timing
- Reset values: FB_WR=0, FB_ADDR=0, FB_DATA=0, FRAME_DONE=0, OVERFLOW=0, SHORT_LINE=0; counters 0; FIFO empty; registered previous mode=0.
- Latency: PX_valid in cycle n gives FB_WR in cycle n+1 at the earliest. There is no combinational bypass from PX_IN to FB_*.
- Throughput: one pixel per cycle sustained while FB_WAIT=0.
- While FB_WR=1 and FB_WAIT=1, FB_ADDR and FB_DATA stay stable.
- When the FIFO is empty, FB_ADDR and FB_DATA hold their last values.
- Reset mid-operation: all queued entries are discarded; outputs return to reset values in the next cycle.
- FRAME_DONE is registered: it pulses in cycle k+1 for an accepted pop in cycle k.

## Test plan
- Reset, then BGP=0xE4, 160 PX_valid pixels with PX_IN cycling 0,1,2,3, FB_WAIT=0 -> writes at addresses 0..159 with shades 0,1,2,3 repeating; FB_WR first high one cycle after the first PX_valid.
- BGP=0x1B, PX_IN=3 -> FB_DATA=0; PX_IN=0 -> FB_DATA=3.
- Full frame (23040 pixels), FB_WAIT=0 -> last address 23039; FRAME_DONE exactly one pulse, the cycle after that pop; the next pixel writes to address 0.
- 100 pixels, then PPU_MODE 3->0, then 1 pixel -> that pixel is written to address 160; SHORT_LINE=1; CLR_STATUS clears it.
- FB_WAIT held high for 40 cycles while 20 pixels stream -> first 16 pixels queued, 4 dropped, OVERFLOW=1, FB_ADDR stable throughout; after release, 16 writes at addresses 0..15; the next pixel is written to address 20.
- Full FIFO with PX_valid and a pop in the same cycle -> pixel accepted, no OVERFLOW; rst asserted mid-stream -> FB_WR=0 the next cycle, FIFO empty.

Source files
------------

// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: pixel sink downstream of the PPU pixel FIFO.
// Maps 2-bit colour indices through BGP to shades, tags each pixel with its
// linear frame-buffer address (y*LINE_W + x), and writes the result to the
// frame-buffer port through a small decoupling FIFO with a wait handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   PX_IN, PX_valid     colour index and its valid strobe
//   PPU_MODE            0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//   BGP                 background palette register
//   CLR_STATUS          clears the sticky flags
//   FB_ADDR/DATA/WR     frame-buffer write request (head of FIFO)
//   FB_WAIT             memory stall; write accepted when FB_WR && !FB_WAIT
//   FRAME_DONE          pulse after the last pixel of a frame is written
//   OVERFLOW            sticky: a pixel was dropped on a full FIFO
//   SHORT_LINE          sticky: H_BLANK entered mid-line
module ppu_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LINE_W     = 160,
  parameter int unsigned LINES      = 144,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        PX_IN,
  input  logic              PX_valid,
  input  logic [1:0]        PPU_MODE,
  input  logic [7:0]        BGP,
  input  logic              CLR_STATUS,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [1:0]        FB_DATA,
  output logic              FB_WR,
  input  logic              FB_WAIT,
  output logic              FRAME_DONE,
  output logic              OVERFLOW,
  output logic              SHORT_LINE
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned X_W   = $clog2(LINE_W);
  localparam int unsigned Y_W   = $clog2(LINES);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        shade;
  } entry_t;

  entry_t              mem_q [FIFO_DEPTH];
  entry_t              mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   line_base_q, line_base_d;
  logic [1:0]          mode_prev_q, mode_prev_d;
  logic                fb_wr_q, fb_wr_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [1:0]          fb_data_q, fb_data_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic                short_line_q, short_line_d;

  logic                full;
  logic                pop;
  logic                push;
  logic                end_of_line;
  logic                last_line;
  logic                hblank_edge;
  logic                vblank_edge;
  entry_t              new_entry;

  // Next-state: position counters, FIFO, outputs and sticky flags
  always_comb begin
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    line_base_d   = line_base_q;
    mode_prev_d   = PPU_MODE;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;

    full          = (cnt_q == CNT_W'(FIFO_DEPTH));
    pop           = fb_wr_q && !FB_WAIT;
    push          = PX_valid && (!full || pop);
    end_of_line   = (x_q == X_W'(LINE_W - 1));
    last_line     = (y_q == Y_W'(LINES - 1));
    hblank_edge   = (PPU_MODE == MODE_HBLANK) && (mode_prev_q != MODE_HBLANK) && (x_q != '0);
    vblank_edge   = (PPU_MODE == MODE_VBLANK) && (mode_prev_q != MODE_VBLANK);

    new_entry.last  = end_of_line && last_line;
    new_entry.addr  = addr_q;
    new_entry.shade = BGP[{PX_IN, 1'b0} +: 2];

    // Counters advance even for dropped pixels so geometry stays aligned
    if (PX_valid) begin
      if (end_of_line) begin
        x_d = '0;
        if (last_line) begin
          y_d         = '0;
          line_base_d = '0;
          addr_d      = '0;
        end else begin
          y_d         = y_q + Y_W'(1);
          line_base_d = line_base_q + ADDR_W'(LINE_W);
          addr_d      = line_base_q + ADDR_W'(LINE_W);
        end
      end else begin
        x_d    = x_q + X_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    // Mode-edge resync overrides the pixel advance in the same cycle
    if (hblank_edge) begin
      x_d = '0;
      if (last_line) begin
        y_d         = '0;
        line_base_d = '0;
        addr_d      = '0;
      end else begin
        y_d         = y_q + Y_W'(1);
        line_base_d = line_base_q + ADDR_W'(LINE_W);
        addr_d      = line_base_q + ADDR_W'(LINE_W);
      end
    end
    if (vblank_edge) begin
      x_d         = '0;
      y_d         = '0;
      line_base_d = '0;
      addr_d      = '0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // Output registers present the next head; they hold while empty
    fb_wr_d = (cnt_d != '0);
    if (fb_wr_d) begin
      fb_addr_d = mem_d[rd_ptr_d].addr;
      fb_data_d = mem_d[rd_ptr_d].shade;
    end

    frame_done_d = pop && mem_q[rd_ptr_q].last;

    // Set has priority over clear
    overflow_d   = (PX_valid && full && !pop) || (overflow_q && !CLR_STATUS);
    short_line_d = hblank_edge || (short_line_q && !CLR_STATUS);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      line_base_q  <= '0;
      mode_prev_q  <= MODE_HBLANK;
      fb_wr_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_line_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      line_base_q  <= line_base_d;
      mode_prev_q  <= mode_prev_d;
      fb_wr_q      <= fb_wr_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      short_line_q <= short_line_d;
    end
  end

  assign FB_ADDR    = fb_addr_q;
  assign FB_DATA    = fb_data_q;
  assign FB_WR      = fb_wr_q;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;
  assign SHORT_LINE = short_line_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Self-checking bench for ppu_fb_writer: directed scenarios plus a random
// phase, compared every cycle against a queue-based reference model.
module tb_ppu_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic [7:0]  bgp;
  logic        clr_status;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_wr;
  logic        fb_wait;
  logic        frame_done;
  logic        overflow;
  logic        short_line;

  ppu_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .PX_IN      (px_in),
    .PX_valid   (px_valid),
    .PPU_MODE   (ppu_mode),
    .BGP        (bgp),
    .CLR_STATUS (clr_status),
    .FB_ADDR    (fb_addr),
    .FB_DATA    (fb_data),
    .FB_WR      (fb_wr),
    .FB_WAIT    (fb_wait),
    .FRAME_DONE (frame_done),
    .OVERFLOW   (overflow),
    .SHORT_LINE (short_line)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: screen position as (x, y), FIFO as a bounded queue
  typedef struct {
    int addr;
    int shade;
    bit last;
  } ment_t;

  ment_t mq[$];
  int m_x, m_y, m_prev;
  bit m_ov, m_sl, m_fd;
  int m_addr_out, m_data_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_x = 0; m_y = 0; m_prev = 0;
    m_ov = 0; m_sl = 0; m_fd = 0;
    m_addr_out = 0; m_data_out = 0;
  endtask

  // Compare outputs with the model, advance the model, then clock once
  task automatic tick();
    ment_t e;
    bit pop, plast, full, acc, ovs, sls;
    int ox, oy;
    if (chk_en) begin
      chk("fb_wr", 32'(fb_wr), 32'(mq.size() != 0));
      chk("fb_addr", 32'(fb_addr), 32'(m_addr_out));
      chk("fb_data", 32'(fb_data), 32'(m_data_out));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("short_line", 32'(short_line), 32'(m_sl));
    end
    if (rst) begin
      model_reset();
    end else begin
      pop   = (mq.size() != 0) && !fb_wait;
      plast = pop && mq[0].last;
      full  = (mq.size() == 16);
      ox = m_x; oy = m_y;
      e.addr  = oy * 160 + ox;
      e.shade = (int'(bgp) >> (2 * int'(px_in))) & 3;
      e.last  = (ox == 159) && (oy == 143);
      acc = px_valid && (!full || pop);
      ovs = px_valid && full && !pop;
      sls = 0;
      if (px_valid) begin
        if (ox == 159) begin
          m_x = 0;
          m_y = (oy == 143) ? 0 : oy + 1;
        end else begin
          m_x = ox + 1;
        end
      end
      if (int'(ppu_mode) == 0 && m_prev != 0 && ox != 0) begin
        m_x = 0;
        m_y = (oy == 143) ? 0 : oy + 1;
        sls = 1;
      end
      if (int'(ppu_mode) == 1 && m_prev != 1) begin
        m_x = 0; m_y = 0;
      end
      m_prev = int'(ppu_mode);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      m_fd = plast;
      m_ov = ovs || (m_ov && !clr_status);
      m_sl = sls || (m_sl && !clr_status);
      if (mq.size() != 0) begin
        m_addr_out = mq[0].addr;
        m_data_out = mq[0].shade;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; px_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int fd_cnt;

  initial begin
    rst = 1'b1; px_in = '0; px_valid = 1'b0; ppu_mode = 2'd0;
    bgp = 8'h00; clr_status = 1'b0; fb_wait = 1'b0;
    model_reset();
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // First line with the identity palette
    bgp = 8'hE4; ppu_mode = 2'd3;
    for (int i = 0; i < 160; i++) begin
      px_valid = 1'b1; px_in = 2'(i % 4);
      tick();
      if (i == 0) chk("first_wr_latency", 32'(fb_wr), 32'd1);
    end
    px_valid = 1'b0;
    repeat (3) tick();

    // Inverted palette
    bgp = 8'h1B;
    px_valid = 1'b1; px_in = 2'd3; tick();
    chk("bgp_inv_idx3", 32'(fb_data), 32'd0);
    px_in = 2'd0; tick();
    chk("bgp_inv_idx0", 32'(fb_data), 32'd3);
    px_valid = 1'b0;
    repeat (2) tick();

    // Full frame with random indices
    do_reset();
    ppu_mode = 2'd3; bgp = 8'($urandom);
    fd_cnt = 0;
    for (int i = 0; i < 23040; i++) begin
      px_valid = 1'b1; px_in = 2'($urandom);
      tick();
      if (i == 23039) chk("last_addr", 32'(fb_addr), 32'd23039);
      fd_cnt += int'(frame_done);
    end
    px_valid = 1'b0;
    tick(); fd_cnt += int'(frame_done);
    tick(); fd_cnt += int'(frame_done);
    chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
    px_valid = 1'b1; tick();
    chk("next_frame_addr", 32'(fb_addr), 32'd0);
    px_valid = 1'b0; tick();

    // Short line: H_BLANK after 100 pixels
    do_reset();
    ppu_mode = 2'd3;
    for (int i = 0; i < 100; i++) begin
      px_valid = 1'b1; px_in = 2'($urandom); tick();
    end
    px_valid = 1'b0; tick(); tick();
    ppu_mode = 2'd0; tick();
    px_valid = 1'b1; tick();
    chk("hblank_resync_addr", 32'(fb_addr), 32'd160);
    chk("short_line_set", 32'(short_line), 32'd1);
    px_valid = 1'b0; clr_status = 1'b1; tick();
    clr_status = 1'b0;
    chk("short_line_clr", 32'(short_line), 32'd0);
    tick();

    // Stall with overflow
    do_reset();
    ppu_mode = 2'd3; fb_wait = 1'b1;
    for (int i = 0; i < 40; i++) begin
      px_valid = (i < 20); px_in = 2'($urandom); tick();
      if (i > 0) chk("stall_addr_stable", 32'(fb_addr), 32'd0);
    end
    chk("overflow_set", 32'(overflow), 32'd1);
    fb_wait = 1'b0; px_valid = 1'b0;
    repeat (16) tick();
    chk("drained", 32'(fb_wr), 32'd0);
    px_valid = 1'b1; tick();
    chk("after_drop_addr", 32'(fb_addr), 32'd20);
    px_valid = 1'b0; tick();

    // Full FIFO with simultaneous push and pop, then reset mid-stream
    do_reset();
    ppu_mode = 2'd3; fb_wait = 1'b1;
    for (int i = 0; i < 16; i++) begin
      px_valid = 1'b1; px_in = 2'($urandom); tick();
    end
    fb_wait = 1'b0; tick();
    chk("full_push_pop_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      fb_wait = ($urandom_range(0, 1) == 0); px_in = 2'($urandom); tick();
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst_mid_fb_wr", 32'(fb_wr), 32'd0);
    px_valid = 1'b0; fb_wait = 1'b0; tick();
    chk("rst_mid_empty", 32'(fb_wr), 32'd0);

    // Random traffic with mode changes, stalls and status clears
    for (int i = 0; i < 600; i++) begin
      px_valid   = ($urandom_range(0, 3) != 0);
      px_in      = 2'($urandom);
      fb_wait    = ($urandom_range(0, 2) == 0);
      clr_status = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) ppu_mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) bgp = 8'($urandom);
      tick();
    end
    px_valid = 1'b0; fb_wait = 1'b0; clr_status = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
